// File: rtl/store_miss_addr_queue_pkg.sv
// Shared definitions for the store/miss address queue.
// Holds the output-select encodings, the miss FSM state encoding and the
// memory-op code driven when a probe owns the output.
package store_miss_addr_queue_pkg;

   // Output source select
   localparam logic [1:0] SEL_NONE  = 2'b00;
   localparam logic [1:0] SEL_STORE = 2'b01;
   localparam logic [1:0] SEL_MISS  = 2'b10;
   localparam logic [1:0] SEL_PROBE = 2'b11;

   // Miss request life cycle
   typedef enum logic [1:0] {
      MISS_IDLE   = 2'b00,
      MISS_PEND   = 2'b01,
      MISS_ISSUED = 2'b10
   } miss_state_e;

   // Op code presented while a probe owns the output
   localparam logic [2:0] PROBE_OP = 3'b010;

endpackage

// File: rtl/store_miss_addr_queue_addr_fifo.sv
// addr_fifo: circular FIFO of {op, address} entries for queued stores.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointers only)
//   push, din     write request and entry data
//   pop           remove the head entry (ignored when empty)
//   dout          head entry
//   full, empty   occupancy status
//   accepted      push taken this cycle
//   entry_valid   per-slot occupancy, indexed by physical slot
//   entry_addr    per-slot address field (low ADDR_W bits of each entry)
module addr_fifo
   import store_miss_addr_queue_pkg::*;
#(
   parameter int WIDTH  = 35,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic                     accepted,
   output logic [DEPTH-1:0]         entry_valid,
   output logic [DEPTH*ADDR_W-1:0]  entry_addr
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic [PW:0]      count;
   logic             pop_ok;
   logic [PW:0]      offset;

   // Extra MSB on each pointer distinguishes full from empty when indices match
   assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_ok   = pop && !empty;
   assign accepted = push && (!full || pop_ok);
   assign count    = wr_ptr - rd_ptr;
   assign dout     = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accepted) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entry storage carries no reset; occupancy comes from the pointers alone
   always_ff @(posedge clk) begin
      if (accepted) mem[wr_ptr[PW-1:0]] <= din;
   end

   // A slot is live when its distance from the read index is below the count
   always_comb begin
      entry_valid = '0;
      entry_addr  = '0;
      offset      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset                        = {1'b0, PW'(i) - rd_ptr[PW-1:0]};
         entry_valid[i]                = (offset < count);
         entry_addr[i*ADDR_W +: ADDR_W] = mem[i][ADDR_W-1:0];
      end
   end

endmodule

// File: rtl/store_miss_addr_queue.sv
// store_miss_addr_queue: arbitrates one output among an external probe, a
// single outstanding cache miss and a FIFO of store addresses.
// Ports:
//   Phi1, ResetB                       clock, asynchronous active-low reset
//   stoPush_s1/stoOp_s1/stoAddr_s1     store enqueue
//   stoFull_s1, stoEmpty_s1, stoOvf_s1 FIFO status, dropped-push pulse
//   missLoad_s1/missOp_s1/missAddr_s1  miss capture; missDone_s1 fill done
//   missBusy_s1                        miss tracker not idle
//   probeReq_s1, probeAddr_s1          external probe (highest priority)
//   outAccept_s1                       consumer takes current output
//   outValid_s1/outSel_s1/outOp_s1/outAddr_s1  arbitrated output
//   shMemAddr_s1, shMemDrv_s1          line-aligned address, driven for misses
//   matchAddr_s1, stoHit_s1            line hazard check against queued stores
module store_miss_addr_queue
   import store_miss_addr_queue_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OP_W   = 3,
   parameter int DEPTH  = 4,
   parameter int LINE_W = 5
) (
   input  logic              Phi1,
   input  logic              ResetB,
   input  logic              stoPush_s1,
   input  logic [OP_W-1:0]   stoOp_s1,
   input  logic [ADDR_W-1:0] stoAddr_s1,
   output logic              stoFull_s1,
   output logic              stoEmpty_s1,
   output logic              stoOvf_s1,
   input  logic              missLoad_s1,
   input  logic [OP_W-1:0]   missOp_s1,
   input  logic [ADDR_W-1:0] missAddr_s1,
   input  logic              missDone_s1,
   output logic              missBusy_s1,
   input  logic              probeReq_s1,
   input  logic [ADDR_W-1:0] probeAddr_s1,
   input  logic              outAccept_s1,
   output logic              outValid_s1,
   output logic [1:0]        outSel_s1,
   output logic [OP_W-1:0]   outOp_s1,
   output logic [ADDR_W-1:0] outAddr_s1,
   output logic [ADDR_W-1:0] shMemAddr_s1,
   output logic              shMemDrv_s1,
   input  logic [ADDR_W-1:0] matchAddr_s1,
   output logic              stoHit_s1
);

   localparam int ENTRY_W = OP_W + ADDR_W;
   // Keeps the line-address bits, clears the offset within a line
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_W) - ADDR_W'(1));

   logic [ENTRY_W-1:0]      fifo_head;
   logic                    push_ok;
   logic                    pop;
   logic [DEPTH-1:0]        entry_valid;
   logic [DEPTH*ADDR_W-1:0] entry_addr;
   miss_state_e             miss_state;
   miss_state_e             miss_state_nxt;
   logic [OP_W-1:0]         miss_op;
   logic [ADDR_W-1:0]       miss_addr;

   addr_fifo #(
      .WIDTH  (ENTRY_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk         (Phi1),
      .rst_n       (ResetB),
      .push        (stoPush_s1),
      .pop         (pop),
      .din         ({stoOp_s1, stoAddr_s1}),
      .dout        (fifo_head),
      .full        (stoFull_s1),
      .empty       (stoEmpty_s1),
      .accepted    (push_ok),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr)
   );

   assign pop = outAccept_s1 && outValid_s1 && (outSel_s1 == SEL_STORE);

   // Registered so the drop is reported as a clean pulse in the following cycle
   always_ff @(posedge Phi1 or negedge ResetB) begin
      if (!ResetB) stoOvf_s1 <= 1'b0;
      else         stoOvf_s1 <= stoPush_s1 && !push_ok;
   end

   always_ff @(posedge Phi1 or negedge ResetB) begin
      if (!ResetB) miss_state <= MISS_IDLE;
      else         miss_state <= miss_state_nxt;
   end

   always_comb begin
      miss_state_nxt = miss_state;
      case (miss_state)
         MISS_IDLE:   if (missLoad_s1) miss_state_nxt = MISS_PEND;
         MISS_PEND:   if (outAccept_s1 && (outSel_s1 == SEL_MISS)) miss_state_nxt = MISS_ISSUED;
         MISS_ISSUED: if (missDone_s1) miss_state_nxt = MISS_IDLE;
         default:     miss_state_nxt = MISS_IDLE;
      endcase
   end

   // Miss payload is data only; it is meaningful just while the tracker is busy
   always_ff @(posedge Phi1) begin
      if ((miss_state == MISS_IDLE) && missLoad_s1) begin
         miss_op   <= missOp_s1;
         miss_addr <= missAddr_s1;
      end
   end

   assign missBusy_s1 = (miss_state != MISS_IDLE);

   always_comb begin
      outValid_s1 = 1'b0;
      outSel_s1   = SEL_NONE;
      outOp_s1    = '0;
      outAddr_s1  = '0;
      if (probeReq_s1) begin
         outValid_s1 = 1'b1;
         outSel_s1   = SEL_PROBE;
         outOp_s1    = OP_W'(PROBE_OP);
         outAddr_s1  = probeAddr_s1;
      end else if (miss_state == MISS_PEND) begin
         outValid_s1 = 1'b1;
         outSel_s1   = SEL_MISS;
         outOp_s1    = miss_op;
         outAddr_s1  = miss_addr;
      end else if (!stoEmpty_s1) begin
         outValid_s1 = 1'b1;
         outSel_s1   = SEL_STORE;
         {outOp_s1, outAddr_s1} = fifo_head;
      end
   end

   assign shMemAddr_s1 = outAddr_s1 & LINE_MASK;
   assign shMemDrv_s1  = outValid_s1 && (outSel_s1 == SEL_MISS);

   // Only entries already in the FIFO compare; a same-cycle push is not yet live
   always_comb begin
      stoHit_s1 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] &&
             (((entry_addr[i*ADDR_W +: ADDR_W] ^ matchAddr_s1) & LINE_MASK) == '0))
            stoHit_s1 = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_miss_addr_queue.sv
// Testbench for store_miss_addr_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_store_miss_addr_queue;

   logic        Phi1;
   logic        ResetB;
   logic        stoPush_s1;
   logic [2:0]  stoOp_s1;
   logic [31:0] stoAddr_s1;
   logic        stoFull_s1;
   logic        stoEmpty_s1;
   logic        stoOvf_s1;
   logic        missLoad_s1;
   logic [2:0]  missOp_s1;
   logic [31:0] missAddr_s1;
   logic        missDone_s1;
   logic        missBusy_s1;
   logic        probeReq_s1;
   logic [31:0] probeAddr_s1;
   logic        outAccept_s1;
   logic        outValid_s1;
   logic [1:0]  outSel_s1;
   logic [2:0]  outOp_s1;
   logic [31:0] outAddr_s1;
   logic [31:0] shMemAddr_s1;
   logic        shMemDrv_s1;
   logic [31:0] matchAddr_s1;
   logic        stoHit_s1;

   store_miss_addr_queue dut (
      .Phi1         (Phi1),
      .ResetB       (ResetB),
      .stoPush_s1   (stoPush_s1),
      .stoOp_s1     (stoOp_s1),
      .stoAddr_s1   (stoAddr_s1),
      .stoFull_s1   (stoFull_s1),
      .stoEmpty_s1  (stoEmpty_s1),
      .stoOvf_s1    (stoOvf_s1),
      .missLoad_s1  (missLoad_s1),
      .missOp_s1    (missOp_s1),
      .missAddr_s1  (missAddr_s1),
      .missDone_s1  (missDone_s1),
      .missBusy_s1  (missBusy_s1),
      .probeReq_s1  (probeReq_s1),
      .probeAddr_s1 (probeAddr_s1),
      .outAccept_s1 (outAccept_s1),
      .outValid_s1  (outValid_s1),
      .outSel_s1    (outSel_s1),
      .outOp_s1     (outOp_s1),
      .outAddr_s1   (outAddr_s1),
      .shMemAddr_s1 (shMemAddr_s1),
      .shMemDrv_s1  (shMemDrv_s1),
      .matchAddr_s1 (matchAddr_s1),
      .stoHit_s1    (stoHit_s1)
   );

   initial Phi1 = 1'b0;
   always #5 Phi1 = ~Phi1;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queued stores plus a pending/issued miss
   logic [31:0] q_addr[$];
   logic [2:0]  q_op[$];
   bit          m_pend;
   bit          m_issued;
   logic [2:0]  m_op;
   logic [31:0] m_addr;
   bit          exp_ovf;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] model_sel();
      if (probeReq_s1)        return 2'd3;
      if (m_pend)             return 2'd2;
      if (q_addr.size() != 0) return 2'd1;
      return 2'd0;
   endfunction

   task automatic check_all();
      logic [1:0]  es;
      logic [2:0]  eo;
      logic [31:0] ea;
      bit          eh;
      es = model_sel();
      eo = 3'd0;
      ea = 32'd0;
      case (es)
         2'd3: begin eo = 3'b010; ea = probeAddr_s1; end
         2'd2: begin eo = m_op;   ea = m_addr;       end
         2'd1: begin eo = q_op[0]; ea = q_addr[0];   end
         default: ;
      endcase
      eh = 1'b0;
      foreach (q_addr[i]) if (q_addr[i][31:5] == matchAddr_s1[31:5]) eh = 1'b1;
      check("valid", outValid_s1, es != 2'd0);
      check("sel", outSel_s1, es);
      if (es != 2'd0) begin
         check("op", outOp_s1, eo);
         check("addr", outAddr_s1, ea);
         check("shmem_addr", shMemAddr_s1, {ea[31:5], 5'b0});
      end
      check("shmem_drv", shMemDrv_s1, es == 2'd2);
      check("full", stoFull_s1, q_addr.size() == 4);
      check("empty", stoEmpty_s1, q_addr.size() == 0);
      check("ovf", stoOvf_s1, exp_ovf);
      check("busy", missBusy_s1, m_pend || m_issued);
      check("hit", stoHit_s1, eh);
   endtask

   task automatic update_model();
      logic [1:0] s;
      bit         popped;
      bit         acc;
      s      = model_sel();
      popped = outAccept_s1 && (s == 2'd1);
      acc    = stoPush_s1 && ((q_addr.size() < 4) || popped);
      if (popped) begin
         void'(q_addr.pop_front());
         void'(q_op.pop_front());
      end
      if (acc) begin
         q_addr.push_back(stoAddr_s1);
         q_op.push_back(stoOp_s1);
      end
      exp_ovf = stoPush_s1 && !acc;
      if (!m_pend && !m_issued) begin
         if (missLoad_s1) begin
            m_pend = 1'b1;
            m_op   = missOp_s1;
            m_addr = missAddr_s1;
         end
      end else if (m_pend) begin
         if (outAccept_s1 && (s == 2'd2)) begin
            m_pend   = 1'b0;
            m_issued = 1'b1;
         end
      end else if (missDone_s1) begin
         m_issued = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      stoPush_s1   = 1'b0;
      stoOp_s1     = 3'd0;
      stoAddr_s1   = 32'd0;
      missLoad_s1  = 1'b0;
      missOp_s1    = 3'd0;
      missAddr_s1  = 32'd0;
      missDone_s1  = 1'b0;
      probeReq_s1  = 1'b0;
      probeAddr_s1 = 32'd0;
      outAccept_s1 = 1'b0;
      matchAddr_s1 = 32'd0;
   endtask

   task automatic cycle();
      #1;
      check_all();
      @(posedge Phi1);
      update_model();
      @(negedge Phi1);
   endtask

   task automatic do_reset();
      idle_inputs();
      ResetB = 1'b0;
      q_addr.delete();
      q_op.delete();
      m_pend   = 1'b0;
      m_issued = 1'b0;
      exp_ovf  = 1'b0;
      #1;
      check("rst_empty", stoEmpty_s1, 1'b1);
      check("rst_busy", missBusy_s1, 1'b0);
      check("rst_valid", outValid_s1, 1'b0);
      check("rst_ovf", stoOvf_s1, 1'b0);
      check_all();
      @(posedge Phi1);
      @(negedge Phi1);
      #1;
      check_all();
      ResetB = 1'b1;
   endtask

   task automatic push_store(input logic [31:0] a, input logic [2:0] op);
      idle_inputs();
      stoPush_s1 = 1'b1;
      stoAddr_s1 = a;
      stoOp_s1   = op;
      cycle();
   endtask

   initial begin
      ResetB = 1'b0;
      idle_inputs();
      do_reset();

      // Fill the FIFO with four stores
      for (int i = 0; i < 4; i++) push_store(32'h100 + 32'(4 * i), 3'b001);
      idle_inputs();
      #1;
      check("fill_full", stoFull_s1, 1'b1);
      check("fill_head", outAddr_s1, 32'h100);
      check("fill_sel", outSel_s1, 2'b01);
      cycle();

      // Overflow push is dropped and pulses once
      push_store(32'h200, 3'b001);
      idle_inputs();
      #1;
      check("ovf_pulse", stoOvf_s1, 1'b1);
      cycle();
      #1;
      check("ovf_clear", stoOvf_s1, 1'b0);

      // Drain in order
      for (int i = 0; i < 4; i++) begin
         idle_inputs();
         outAccept_s1 = 1'b1;
         #1;
         check("drain_order", outAddr_s1, 32'h100 + 32'(4 * i));
         cycle();
      end
      idle_inputs();
      #1;
      check("drained_empty", stoEmpty_s1, 1'b1);
      cycle();

      // Miss takes priority over queued stores
      push_store(32'h100, 3'b001);
      push_store(32'h140, 3'b101);
      idle_inputs();
      missLoad_s1 = 1'b1;
      missOp_s1   = 3'b011;
      missAddr_s1 = 32'h1234_5678;
      cycle();
      idle_inputs();
      #1;
      check("miss_sel", outSel_s1, 2'b10);
      check("miss_shmem", shMemAddr_s1, 32'h1234_5660);
      check("miss_drv", shMemDrv_s1, 1'b1);

      // Probe overrides a pending miss; accepting it leaves the miss pending
      probeReq_s1  = 1'b1;
      probeAddr_s1 = 32'hABCD_0000;
      outAccept_s1 = 1'b1;
      #1;
      check("probe_sel", outSel_s1, 2'b11);
      check("probe_op", outOp_s1, 3'b010);
      cycle();
      idle_inputs();
      #1;
      check("miss_still_pend", outSel_s1, 2'b10);

      // Line hazard compare
      matchAddr_s1 = 32'h0000_0110;
      #1;
      check("hit_same_line", stoHit_s1, 1'b1);
      matchAddr_s1 = 32'h0000_0120;
      #1;
      check("hit_other_line", stoHit_s1, 1'b0);
      cycle();

      // Issue the miss, ignore a reload, then complete it
      idle_inputs();
      outAccept_s1 = 1'b1;
      cycle();
      idle_inputs();
      missLoad_s1 = 1'b1;
      missAddr_s1 = 32'h0000_DEAD;
      #1;
      check("issued_sel", outSel_s1, 2'b01);
      check("issued_busy", missBusy_s1, 1'b1);
      cycle();
      idle_inputs();
      missDone_s1 = 1'b1;
      #1;
      check("reload_ignored", outSel_s1, 2'b01);
      cycle();
      idle_inputs();
      #1;
      check("done_idle", missBusy_s1, 1'b0);
      cycle();

      // Reset with a full FIFO and an issued miss
      push_store(32'h180, 3'b001);
      push_store(32'h184, 3'b001);
      idle_inputs();
      missLoad_s1 = 1'b1;
      missAddr_s1 = 32'h0000_4000;
      cycle();
      idle_inputs();
      outAccept_s1 = 1'b1;
      cycle();
      idle_inputs();
      #1;
      check("pre_rst_full", stoFull_s1, 1'b1);
      check("pre_rst_busy", missBusy_s1, 1'b1);
      do_reset();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         idle_inputs();
         stoPush_s1   = ($urandom_range(0, 1) == 1);
         stoOp_s1     = 3'($urandom_range(0, 7));
         stoAddr_s1   = 32'($urandom_range(0, 255)) << 2;
         missLoad_s1  = ($urandom_range(0, 7) == 0);
         missOp_s1    = 3'($urandom_range(0, 7));
         missAddr_s1  = $urandom;
         missDone_s1  = ($urandom_range(0, 3) == 0);
         probeReq_s1  = ($urandom_range(0, 7) == 0);
         probeAddr_s1 = $urandom;
         outAccept_s1 = ($urandom_range(0, 1) == 1);
         matchAddr_s1 = 32'($urandom_range(0, 1023));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
